// File: rtl/lm75a_temp_bcd.sv
// Converts a raw LM75A temperature word into sign plus hundreds/tens/ones/tenths BCD digits.
// An iterative double-dabble core does one shift per clock; a 1-deep buffer holds a pending sample.
module lm75a_temp_bcd #(
  parameter int unsigned ROUND       = 0,
  parameter int unsigned BLANK_ZEROS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic        in_valid,
  output logic        busy,
  output logic        neg,
  output logic [3:0]  d_hund,
  output logic [3:0]  d_tens,
  output logic [3:0]  d_ones,
  output logic [3:0]  d_tenth,
  output logic        out_valid
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [12:0] RndAdd = (ROUND != 0) ? 13'd2 : 13'd0;
  localparam bit          Blank  = (BLANK_ZEROS != 0);

  state_e      state_q, state_d;
  logic [10:0] cap_q, cap_d;
  logic        pend_q, pend_d;
  logic        negr_q, negr_d;
  logic [10:0] t_q, t_d;
  // Hundreds never exceeds 1, so its nibble needs no correction and bit 15 is never stored.
  logic [14:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, tenth_q, tenth_d;

  logic [10:0] mag;
  logic [10:0] t_load;
  logic [14:0] adj;
  logic [15:0] shift_bcd;
  logic        blank_h;
  logic        unused_data;

  assign unused_data = ^data[4:0];

  assign mag    = cap_q[10] ? (~cap_q + 11'd1) : cap_q;
  // Tenths of a degree: mag * 0.125 * 10 = mag * 5 / 4.
  assign t_load = 11'(((13'(mag) * 13'd5) + RndAdd) >> 2);

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shift_bcd = {adj, t_q[10]};
  assign blank_h   = Blank && (shift_bcd[15:12] == 4'd0);

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    pend_d  = pend_q;
    negr_d  = negr_q;
    t_d     = t_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tenth_d = tenth_q;

    if (in_valid) begin
      cap_d  = data[15:5];
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q) state_d = StLoad;
      end
      StLoad: begin
        if (!in_valid) pend_d = 1'b0;
        negr_d  = cap_q[10] && (t_load != 11'd0);
        t_d     = t_load;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = shift_bcd[14:0];
        t_d   = {t_q[9:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = StDone;
          neg_d   = negr_q;
          hund_d  = blank_h ? 4'hF : shift_bcd[15:12];
          tens_d  = (blank_h && shift_bcd[11:8] == 4'd0) ? 4'hF : shift_bcd[11:8];
          ones_d  = shift_bcd[7:4];
          tenth_d = shift_bcd[3:0];
        end
      end
      StDone: begin
        state_d = pend_q ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      negr_q  <= 1'b0;
      t_q     <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      tenth_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      negr_q  <= negr_d;
      t_q     <= t_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      tenth_q <= tenth_d;
    end
  end

  assign busy      = (state_q == StLoad) || (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign neg       = neg_q;
  assign d_hund    = hund_q;
  assign d_tens    = tens_q;
  assign d_ones    = ones_q;
  assign d_tenth   = tenth_q;

endmodule

// File: tb/tb_lm75a_temp_bcd.sv
// Directed bench for lm75a_temp_bcd: default build plus a ROUND=1, BLANK_ZEROS=0 build fed in parallel.
module tb_lm75a_temp_bcd;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        in_valid;

  logic        busy, neg, out_valid;
  logic [3:0]  d_hund, d_tens, d_ones, d_tenth;
  logic        a_busy, a_neg, a_out_valid;
  logic [3:0]  a_hund, a_tens, a_ones, a_tenth;

  logic [15:0] dig, a_dig;
  assign dig   = {d_hund, d_tens, d_ones, d_tenth};
  assign a_dig = {a_hund, a_tens, a_ones, a_tenth};

  int checks = 0;
  int errors = 0;

  lm75a_temp_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .in_valid (in_valid),
    .busy     (busy),
    .neg      (neg),
    .d_hund   (d_hund),
    .d_tens   (d_tens),
    .d_ones   (d_ones),
    .d_tenth  (d_tenth),
    .out_valid(out_valid)
  );

  lm75a_temp_bcd #(
    .ROUND      (1),
    .BLANK_ZEROS(0)
  ) dut_alt (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .in_valid (in_valid),
    .busy     (a_busy),
    .neg      (a_neg),
    .d_hund   (a_hund),
    .d_tens   (a_tens),
    .d_ones   (a_ones),
    .d_tenth  (a_tenth),
    .out_valid(a_out_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, out_valid, neg, dig} !== 19'h0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got busy=%b ov=%b neg=%b dig=%h, want all 0",
                 c, busy, out_valid, neg, dig);
      end
      checks++;
      if ({a_busy, a_out_valid, a_neg, a_dig} !== 19'h0) begin
        errors++;
        $display("FAIL reset_idle_alt cycle %0d: got busy=%b ov=%b neg=%b dig=%h, want all 0",
                 c, a_busy, a_out_valid, a_neg, a_dig);
      end
    end
  endtask

  task automatic test_conversions;
    localparam int N = 12;
    logic [15:0] vd [N];
    logic        vn [N];
    logic [15:0] ve [N];
    logic [15:0] va [N];
    vd = '{16'h1900, 16'h191F, 16'h7D00, 16'hE500, 16'h00E0, 16'hFFE0,
           16'h0000, 16'h8000, 16'h0040, 16'h0060, 16'h0A00, 16'h6400};
    vn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ve = '{16'hF250, 16'hF250, 16'h1250, 16'hF270, 16'hFF08, 16'hFF01,
           16'hFF00, 16'h1280, 16'hFF02, 16'hFF03, 16'hF100, 16'h1000};
    va = '{16'h0250, 16'h0250, 16'h1250, 16'h0270, 16'h0009, 16'h0001,
           16'h0000, 16'h1280, 16'h0003, 16'h0004, 16'h0100, 16'h1000};
    for (int i = 0; i < N; i++) begin
      int lat;
      lat = 0;
      @(negedge clk);
      data = vd[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
        @(posedge clk); #1;
        if (n == 1) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL conv_busy data=%h: got busy=%b, want 1", vd[i], busy);
          end
        end
        if (out_valid === 1'b1) lat = n;
      end
      checks++;
      if (lat != 13) begin
        errors++;
        $display("FAIL conv_latency data=%h: got %0d cycles, want 13", vd[i], lat);
      end
      checks++;
      if ({neg, dig} !== {vn[i], ve[i]}) begin
        errors++;
        $display("FAIL conv_value data=%h: got neg=%b dig=%h, want neg=%b dig=%h",
                 vd[i], neg, dig, vn[i], ve[i]);
      end
      checks++;
      if ({a_out_valid, a_neg, a_dig} !== {1'b1, vn[i], va[i]}) begin
        errors++;
        $display("FAIL conv_alt data=%h: got ov=%b neg=%b dig=%h, want ov=1 neg=%b dig=%h",
                 vd[i], a_out_valid, a_neg, a_dig, vn[i], va[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL conv_done_busy data=%h: got busy=%b, want 0", vd[i], busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, neg, dig} !== {1'b0, vn[i], ve[i]}) begin
        errors++;
        $display("FAIL conv_hold data=%h: got ov=%b neg=%b dig=%h, want ov=0 neg=%b dig=%h",
                 vd[i], out_valid, neg, dig, vn[i], ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          pcnt;
    int          pcyc [2];
    logic [16:0] pval [2];
    pcnt = 0;
    pcyc = '{0, 0};
    pval = '{17'h0, 17'h0};
    @(negedge clk);
    data = 16'h1900;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin
        data = 16'h7D00;
        in_valid = 1'b1;
      end else if (c == 6) begin
        data = 16'hE500;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        if (pcnt < 2) begin
          pcyc[pcnt] = c;
          pval[pcnt] = {neg, dig};
        end
        pcnt++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pcnt != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d out_valid pulses, want 2", pcnt);
    end
    checks++;
    if (pcyc[0] != 13 || pcyc[1] != 26) begin
      errors++;
      $display("FAIL b2b_timing: got pulses at %0d,%0d, want 13,26", pcyc[0], pcyc[1]);
    end
    checks++;
    if (pval[0] !== {1'b0, 16'hF250}) begin
      errors++;
      $display("FAIL b2b_first: got %h, want %h", pval[0], {1'b0, 16'hF250});
    end
    checks++;
    if (pval[1] !== {1'b1, 16'hF270}) begin
      errors++;
      $display("FAIL b2b_second: got %h, want %h", pval[1], {1'b1, 16'hF270});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int spurious;
    @(negedge clk);
    data = 16'h1900;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, neg, dig} !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy=%b ov=%b neg=%b dig=%h, want all 0",
               busy, out_valid, neg, dig);
    end
    checks++;
    if ({a_busy, a_out_valid, a_neg, a_dig} !== 19'h0) begin
      errors++;
      $display("FAIL rst_mid_clear_alt: got busy=%b ov=%b neg=%b dig=%h, want all 0",
               a_busy, a_out_valid, a_neg, a_dig);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d cycles with busy/out_valid, want 0", spurious);
    end
    lat = 0;
    @(negedge clk);
    data = 16'h7D00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) lat = n;
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL rst_mid_latency: got %0d cycles, want 13", lat);
    end
    checks++;
    if ({neg, dig} !== {1'b0, 16'h1250}) begin
      errors++;
      $display("FAIL rst_mid_value: got neg=%b dig=%h, want neg=0 dig=1250", neg, dig);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data = 16'h0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_conversions();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
